mem_sweep_ctrl: RTL and testbench
=================================

Name: mem_sweep_ctrl

Overview:
- Address/data sequencer sitting directly upstream of the block-RAM memory wrapper. Drives its raddr/waddr/din and consumes its dout.
- Provides two whole-array operations for bitstream re-init experiments:
  - FILL: write a deterministic ramp pattern to every word.
  - READ sweep: read every word, compute a running checksum, and write each word back unchanged.
- The memory wrapper writes ram[waddr] <= din on every clock with no write enable. This block therefore owns a sacrificial PARK_ADDR that absorbs all "don't-care" writes.

Parameters:
- WID_MEM, 18, data word width (matches memory din/dout).
- ADDR_W, 12, address width (matches memory raddr/waddr).
- DEPTH_MEM, 4096, number of words swept, addresses 0..DEPTH_MEM-1; DEPTH_MEM <= 2**ADDR_W.
- PARK_ADDR, DEPTH_MEM-1, address receiving idle/invalid writes; its contents are not preserved.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low (asserted when 0).
- start  in  1  start request, sampled only in IDLE.
- mode  in  1  0 = READ sweep, 1 = FILL; sampled with start.
- fill_seed  in  WID_MEM  first FILL data word; sampled with start.
- raddr  out  ADDR_W  memory read address (registered).
- waddr  out  ADDR_W  memory write address (registered).
- din  out  WID_MEM  memory write data.
- dout  in  WID_MEM  memory read data (1-cycle registered read).
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the operation completes.
- checksum  out  WID_MEM  result of the last operation, held until the next start.
- word_count  out  ADDR_W+1  number of words accumulated into checksum.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; raddr=waddr=PARK_ADDR; busy=0; done=0; checksum=0; word_count=0.
  - Reset wins over start. Reset mid-operation aborts immediately: no done pulse, partially swept memory is left as-is.
- Checksum update per accumulated word d: csum <= {csum[WID_MEM-2:0], csum[WID_MEM-1]} ^ d (rotate-left-1, then XOR). Cleared to 0 at accepted start.
- States: IDLE, RD_SWEEP, RD_DRAIN, FILL.
- IDLE:
  - raddr=waddr=PARK_ADDR; din=0.
  - start=1 at edge e0 latches mode and fill_seed, sets busy=1, clears checksum and word_count, and enters RD_SWEEP or FILL.
  - start in any non-IDLE state is ignored.
- RD_SWEEP: raddr <= 0,1,...,DEPTH_MEM-1 at edges e0..e(DEPTH_MEM-1). A valid-tag pipeline follows each address.
  - waddr register = raddr delayed one edge (PARK_ADDR when the tag is invalid).
  - din = dout combinationally while the write tag is valid, otherwise 0. Every swept word is therefore rewritten with its own value, and array contents are unchanged.
  - Address j is read at edge e(j+1) and accumulated at edge e(j+2).
  - After the last raddr is issued, go to RD_DRAIN; raddr returns to PARK_ADDR.
- RD_DRAIN: waits until the last word (address DEPTH_MEM-1) is accumulated at edge e(DEPTH_MEM+1). At that same edge: done<=1, busy<=0, state IDLE.
- FILL:
  - waddr <= k and din <= fill_seed + k (mod 2**WID_MEM) at edge e_k, for k = 0..DEPTH_MEM-1. Memory writes word k at edge e(k+1).
  - raddr stays PARK_ADDR.
  - Each written word is accumulated into checksum with the same formula. A FILL checksum therefore equals a later READ-sweep checksum of the same contents.
  - At edge e(DEPTH_MEM): waddr<=PARK_ADDR, done<=1, busy<=0, state IDLE.
- done is high for exactly one cycle. start may be reasserted in the cycle done is high; it is accepted at the next edge.
- word_count increments per accumulated word and ends at DEPTH_MEM. Counter width ADDR_W+1 avoids wrap at DEPTH_MEM=2**ADDR_W.
- Address counters never wrap within an operation. Termination compares against DEPTH_MEM-1, not against counter overflow.

Test Plan:
- DEPTH_MEM=4, contents {1,2,3,4}, READ sweep -> checksum=0x00002, word_count=4, done pulses one cycle after edge e5, contents still {1,2,3,4}.
- Defaults, FILL seed=0x00005 -> done after edge e4096; word 10 reads 0x0000F; word 0x3FFFF-offset ramp wraps mod 2**18; busy high 4096 cycles.
- FILL seed=0x00100, then READ sweep -> READ checksum equals FILL checksum (PARK_ADDR excluded by making PARK_ADDR outside the sweep, i.e. DEPTH_MEM=4095); contents unchanged after the READ sweep.
- Pulse start (mode=1) during READ sweep at cycle 100 -> ignored; READ completes normally with one done pulse.
- reset=0 for one edge at READ sweep cycle 50 -> next cycle busy=0, raddr=waddr=PARK_ADDR, checksum=0, no done pulse; a new start runs a full sweep.
- Back-to-back: start held high through done -> second operation begins the edge after the done cycle, and checksum clears at that edge.

Source files
------------

// File: rtl/mem_sweep_ctrl.sv
// rtl/mem_sweep_ctrl.sv - whole-array FILL / READ-sweep sequencer for a no-write-enable block RAM
//
// Drives the raddr/waddr/din side of a block-RAM wrapper that writes
// ram[waddr] <= din on every clock and returns dout one cycle after raddr.
// Two operations are provided:
//   FILL       : word k <= fill_seed + k for k = 0..DEPTH_MEM-1
//   READ sweep : read every word, fold it into a running checksum and
//                write it straight back so the array is left unchanged
// Any write this block does not care about goes to PARK_ADDR, so that one
// word is sacrificial and its contents are not preserved.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low
//   start      in   operation request, only looked at while idle
//   mode       in   0 = READ sweep, 1 = FILL (sampled with start)
//   fill_seed  in   first FILL data word (sampled with start)
//   raddr      out  memory read address (registered)
//   waddr      out  memory write address (registered)
//   din        out  memory write data
//   dout       in   memory read data, one cycle after raddr
//   busy       out  high from the accepted start until done
//   done       out  one-cycle completion pulse
//   checksum   out  rotate-left-1 / XOR fold of the words handled
//   word_count out  number of words folded into checksum

module mem_sweep_ctrl #(
  parameter int WID_MEM   = 18,
  parameter int ADDR_W    = 12,
  parameter int DEPTH_MEM = 4096,
  parameter int PARK_ADDR = DEPTH_MEM - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WID_MEM-1:0] fill_seed,
  output logic [ADDR_W-1:0]  raddr,
  output logic [ADDR_W-1:0]  waddr,
  output logic [WID_MEM-1:0] din,
  input  logic [WID_MEM-1:0] dout,
  output logic               busy,
  output logic               done,
  output logic [WID_MEM-1:0] checksum,
  output logic [ADDR_W:0]    word_count
);

  localparam logic [ADDR_W-1:0] PARK = ADDR_W'(PARK_ADDR);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_MEM - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_SWEEP = 2'd1,
    S_RD_DRAIN = 2'd2,
    S_FILL     = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // rd_wr_vld tags the read-back word currently on dout: it marks that waddr
  // holds the address that dout was read from, so din can forward dout.
  logic               rd_wr_vld;
  // Registered FILL data; zero whenever no FILL is in progress so din idles at 0.
  logic [WID_MEM-1:0] fill_din;

  logic accept;
  logic sweep_last;
  logic fill_last;
  logic drain_done;
  logic finish;
  logic acc_en;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = mode ? S_FILL : S_RD_SWEEP;
        end
      end
      S_RD_SWEEP: begin
        if (sweep_last) begin
          state_nxt = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: begin
        if (drain_done) begin
          state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (fill_last) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    accept     = (state == S_IDLE) && start;
    // Termination is an explicit compare against the last address so the
    // counters never rely on wrapping, even when DEPTH_MEM == 2**ADDR_W.
    sweep_last = (state == S_RD_SWEEP) && (raddr == LAST);
    fill_last  = (state == S_FILL) && (waddr == LAST);
    // The drain state only waits for the final read-back word to land.
    drain_done = (state == S_RD_DRAIN) && rd_wr_vld;
    finish     = drain_done || fill_last;
    // A word is folded into the checksum on the same edge it is written.
    acc_en     = rd_wr_vld || (state == S_FILL);
    // Read-back forwards dout unregistered so it lands on the edge after the read.
    din        = rd_wr_vld ? dout : fill_din;
  end

  // ---------------------------------------------------------------------------
  // Address, data and status datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      raddr      <= PARK;
      waddr      <= PARK;
      fill_din   <= '0;
      rd_wr_vld  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
      word_count <= '0;
    end else begin
      done      <= finish;
      // Every address issued during the sweep comes back one edge later.
      rd_wr_vld <= (state == S_RD_SWEEP);

      unique case (state)
        S_IDLE: begin
          raddr    <= (accept && !mode) ? '0 : PARK;
          waddr    <= (accept && mode) ? '0 : PARK;
          fill_din <= (accept && mode) ? fill_seed : '0;
        end
        S_RD_SWEEP: begin
          raddr    <= sweep_last ? PARK : raddr + 1'b1;
          waddr    <= raddr;
          fill_din <= '0;
        end
        S_RD_DRAIN: begin
          raddr    <= PARK;
          waddr    <= PARK;
          fill_din <= '0;
        end
        S_FILL: begin
          raddr    <= PARK;
          waddr    <= fill_last ? PARK : waddr + 1'b1;
          // Ramp wraps naturally modulo 2**WID_MEM.
          fill_din <= fill_last ? '0 : fill_din + 1'b1;
        end
        default: begin
          raddr    <= PARK;
          waddr    <= PARK;
          fill_din <= '0;
        end
      endcase

      if (accept) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end

      if (accept) begin
        checksum   <= '0;
        word_count <= '0;
      end else if (acc_en) begin
        checksum   <= {checksum[WID_MEM-2:0], checksum[WID_MEM-1]} ^ din;
        word_count <= word_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// tb/tb_mem_sweep_ctrl.sv - randomized self-checking bench for mem_sweep_ctrl with a RAM model
module tb_mem_sweep_ctrl;

  localparam int W    = 18;
  localparam int A    = 6;
  localparam int D    = 63;
  localparam int PARK = 63;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [W-1:0]  fill_seed;
  logic [A-1:0]  raddr;
  logic [A-1:0]  waddr;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          busy;
  logic          done;
  logic [W-1:0]  checksum;
  logic [A:0]    word_count;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_mem [0:D-1];

  always #5 clk = ~clk;

  mem_sweep_ctrl #(
    .WID_MEM  (W),
    .ADDR_W   (A),
    .DEPTH_MEM(D),
    .PARK_ADDR(PARK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .fill_seed (fill_seed),
    .raddr     (raddr),
    .waddr     (waddr),
    .din       (din),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .word_count(word_count)
  );

  // Block RAM wrapper model: unconditional write, registered read.
  logic [W-1:0] ram [0:(1<<A)-1];
  logic         pl_en;
  logic [A-1:0] pl_addr;
  logic [W-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else       ram[waddr]   <= din;
    dout <= ram[raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] fold(input logic [W-1:0] c, input logic [W-1:0] d);
    return {c[W-2:0], c[W-1]} ^ d;
  endfunction

  task automatic check_contents(input string tag);
    for (int i = 0; i < D; i++) begin
      check($sformatf("%s_mem[%0d]", tag, i), 32'(ram[i]), 32'(exp_mem[i]));
    end
  endtask

  // Runs one operation from an idle negedge. inj >= 0 pulses a FILL start at
  // that cycle; rst_at >= 0 aborts with reset at that cycle; keep leaves start
  // high at the end so the next call begins back-to-back.
  task automatic run_op(input logic m, input logic [W-1:0] seed, input int inj,
                        input int rst_at, input bit keep);
    logic [W-1:0] words [0:D-1];
    logic [W-1:0] pfx   [0:D];
    int last_k;
    int cnt;
    int pulses;

    for (int i = 0; i < D; i++) words[i] = m ? W'(seed + i) : exp_mem[i];
    pfx[0] = '0;
    for (int i = 0; i < D; i++) pfx[i+1] = fold(pfx[i], words[i]);
    last_k = m ? D : D + 1;

    start = 1'b1; mode = m; fill_seed = seed;
    @(posedge clk);
    @(negedge clk);
    if (!keep) start = 1'b0;

    for (int k = 0; k <= last_k; k++) begin
      check($sformatf("busy@%0d", k), 32'(busy), (k < last_k) ? 1 : 0);
      check($sformatf("done@%0d", k), 32'(done), (k == last_k) ? 1 : 0);
      if (m) begin
        check($sformatf("f_raddr@%0d", k), 32'(raddr), PARK);
        check($sformatf("f_waddr@%0d", k), 32'(waddr), (k < D) ? k : PARK);
        check($sformatf("f_din@%0d", k), 32'(din), (k < D) ? 32'(W'(seed + k)) : 0);
        cnt = k;
      end else begin
        check($sformatf("r_raddr@%0d", k), 32'(raddr), (k < D) ? k : PARK);
        check($sformatf("r_waddr@%0d", k), 32'(waddr), (k >= 1 && k <= D) ? k - 1 : PARK);
        check($sformatf("r_din@%0d", k), 32'(din), (k >= 1 && k <= D) ? 32'(words[k-1]) : 0);
        cnt = (k >= 2) ? k - 1 : 0;
      end
      check($sformatf("word_count@%0d", k), 32'(word_count), cnt);
      check($sformatf("checksum@%0d", k), 32'(checksum), 32'(pfx[cnt]));

      if (inj >= 0 && k == inj) begin
        start = 1'b1; mode = ~m;
      end else if (inj >= 0 && k == inj + 1) begin
        start = keep; mode = m;
      end

      if (k == rst_at) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_raddr", 32'(raddr), PARK);
        check("abort_waddr", 32'(waddr), PARK);
        check("abort_checksum", 32'(checksum), 0);
        check("abort_word_count", 32'(word_count), 0);
        pulses = 0;
        for (int c = 0; c < D + 4; c++) begin
          @(negedge clk);
          if (done || busy) pulses++;
        end
        check("abort_no_done", 32'(pulses), 0);
        check_contents("abort");
        return;
      end

      if (k < last_k) @(negedge clk);
    end

    if (m) begin
      for (int i = 0; i < D; i++) exp_mem[i] = words[i];
    end
    if (!keep) begin
      @(negedge clk);
      check("done_width", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
      check("hold_checksum", 32'(checksum), 32'(pfx[D]));
      check("hold_word_count", 32'(word_count), D);
      check_contents(m ? "fill" : "read");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s;
    logic         m;

    reset = 1'b0; start = 1'b0; mode = 1'b0; fill_seed = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    // Preload ramp 1..63 while held in reset; park word outside the sweep.
    for (int i = 0; i < (1 << A); i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = A'(i); pl_data = W'(i + 1);
      if (i < D) exp_mem[i] = W'(i + 1);
    end
    @(negedge clk);
    pl_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_raddr", 32'(raddr), PARK);
    check("rst_waddr", 32'(waddr), PARK);
    check("rst_din", 32'(din), 0);
    check("rst_checksum", 32'(checksum), 0);
    check("rst_word_count", 32'(word_count), 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    run_op(1'b0, '0, -1, -1, 1'b0);
    run_op(1'b1, 18'h00005, -1, -1, 1'b0);
    check("fill_word10", 32'(ram[10]), 32'h0000F);
    run_op(1'b1, 18'h3FFF0, -1, -1, 1'b0);
    check("fill_wrap_word62", 32'(ram[62]), 32'h0002E);
    run_op(1'b0, '0, -1, -1, 1'b0);
    run_op(1'b0, '0, 20, -1, 1'b0);
    run_op(1'b0, '0, -1, 20, 1'b0);
    run_op(1'b0, '0, -1, -1, 1'b0);

    s = W'($urandom);
    run_op(1'b1, s, -1, -1, 1'b1);
    run_op(1'b0, '0, -1, -1, 1'b1);
    s = W'($urandom);
    run_op(1'b1, s, -1, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      m = 1'($urandom_range(0, 1));
      s = W'($urandom);
      run_op(m, s, (r == 2) ? int'($urandom_range(1, D - 2)) : -1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
